// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter states, parity modes and
// the bit-period helper used by both the tx and rx paths.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_SEND_BYTE,
    S_PARITY,
    S_STOP
  } tx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  function automatic int calc_cycle(input int clk_fre, input int baud);
    return (clk_fre * 1000000) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous first-word fall-through FIFO with count-based
// full/empty flags, used to queue bytes ahead of the serialiser.
module uart_tx_fifo #(
  parameter int W  = 8,
  parameter int AW = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_i,
  input  logic [W-1:0] wdata_i,
  input  logic         rd_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q;
  logic [AW-1:0] rp_q;
  logic [AW:0]   cnt_q;
  logic          do_wr;
  logic          do_rd;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_wr   = wr_i && !full_o;
  assign do_rd   = rd_i && !empty_o;
  assign rdata_o = mem_q[rp_q];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_wr) wp_q <= wp_q + 1'b1;
      if (do_rd) rp_q <= rp_q + 1'b1;
      unique case ({do_wr, do_rd})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wp_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: byte FIFO in front of a start/data/parity/stop
// serialiser driving a registered, idle-high tx_pin.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FRE   = 200,
  parameter int BAUD_RATE = 115200,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int FIFO_AW   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_data_valid,
  output logic       tx_data_ready,
  output logic       tx_pin,
  output logic       tx_busy
);

  localparam int          CYCLE     = calc_cycle(CLK_FRE, BAUD_RATE);
  localparam logic [15:0] LAST      = 16'(CYCLE - 1);
  localparam logic [2:0]  LAST_STOP = 3'(STOP_BITS - 1);

  tx_state_e   state_q;
  logic [15:0] cyc_q;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;
  logic        par_q;
  logic        pin_q;
  logic        pend_q;

  logic       full;
  logic       empty;
  logic       pop;
  logic       bit_end;
  logic       par_d;
  logic [7:0] fdata;

  uart_tx_fifo #(
    .W  (8),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_i    (tx_data_valid),
    .wdata_i (tx_data),
    .rd_i    (pop),
    .rdata_o (fdata),
    .full_o  (full),
    .empty_o (empty)
  );

  assign bit_end = (cyc_q == LAST);
  assign par_d   = (PARITY == PAR_ODD) ? ~^fdata : ^fdata;

  // From idle, launch off the registered non-empty flag; between
  // frames, pop straight from the FIFO so there is no gap.
  assign pop = !empty &&
    ((state_q == S_IDLE && pend_q) ||
     (state_q == S_STOP && bit_end && bit_q == LAST_STOP));

  assign tx_data_ready = !full;
  assign tx_pin        = pin_q;
  assign tx_busy       = (state_q != S_IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      pin_q   <= 1'b1;
      pend_q  <= 1'b0;
    end else begin
      pend_q <= !empty;
      cyc_q  <= cyc_q + 16'd1;
      unique case (state_q)
        S_IDLE: begin
          cyc_q <= '0;
          pin_q <= 1'b1;
          if (pop) begin
            shift_q <= fdata;
            par_q   <= par_d;
            pin_q   <= 1'b0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            cyc_q   <= '0;
            bit_q   <= '0;
            pin_q   <= shift_q[0];
            state_q <= S_SEND_BYTE;
          end
        end
        S_SEND_BYTE: begin
          if (bit_end) begin
            cyc_q <= '0;
            if (bit_q == 3'd7) begin
              bit_q <= '0;
              if (PARITY != PAR_NONE) begin
                pin_q   <= par_q;
                state_q <= S_PARITY;
              end else begin
                pin_q   <= 1'b1;
                state_q <= S_STOP;
              end
            end else begin
              bit_q <= bit_q + 3'd1;
              pin_q <= shift_q[bit_q + 3'd1];
            end
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            cyc_q   <= '0;
            pin_q   <= 1'b1;
            state_q <= S_STOP;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            cyc_q <= '0;
            if (bit_q == LAST_STOP) begin
              bit_q <= '0;
              if (pop) begin
                shift_q <= fdata;
                par_q   <= par_d;
                pin_q   <= 1'b0;
                state_q <= S_START;
              end else begin
                state_q <= S_IDLE;
              end
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
